// File: rtl/pipe_stage_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_if
// Bundles the upstream and downstream sides of one retirement-payload pipeline
// boundary (typically MEM->WB), plus the flush and synchronised external
// interrupt that act on it.
//
// Handshake: on each side a transfer happens on a rising clk edge where
// valid and ready are both 1. A source holds valid and its payload stable
// until the transfer; ready never depends on the same side's valid.
//
// Signals:
//   flush, ext_int                      control into the stage
//   up_valid/up_ready + up_* payload    upstream side
//   dn_valid/dn_ready + dn_* payload    downstream side (head entry)
//   dn_exc_code/dn_int/dn_exc_any/dn_rf_we  decoded view of the head entry
// Modports:
//   slave  - the stage itself
//   master - the environment driving the stage
// ---------------------------------------------------------------------------
interface pipe_stage_skid_if #(
  parameter int XLEN   = 32,
  parameter int RF_AW  = 5,
  parameter int EXC_W  = 4,
  parameter int CODE_W = (EXC_W > 1) ? $clog2(EXC_W) : 1
) ();
  logic              flush;
  logic              ext_int;

  logic              up_valid;
  logic              up_ready;
  logic [XLEN-1:0]   up_pc;
  logic [XLEN-1:0]   up_inst;
  logic [XLEN-1:0]   up_data;
  logic              up_rf_we;
  logic [RF_AW-1:0]  up_rf_waddr;
  logic [EXC_W-1:0]  up_exc;
  logic              up_int;

  logic              dn_valid;
  logic              dn_ready;
  logic [XLEN-1:0]   dn_pc;
  logic [XLEN-1:0]   dn_inst;
  logic [XLEN-1:0]   dn_data;
  logic [RF_AW-1:0]  dn_rf_waddr;
  logic [EXC_W-1:0]  dn_exc;
  logic [CODE_W-1:0] dn_exc_code;
  logic              dn_int;
  logic              dn_exc_any;
  logic              dn_rf_we;

  modport slave (
    input  flush, ext_int,
    input  up_valid, up_pc, up_inst, up_data, up_rf_we, up_rf_waddr, up_exc, up_int,
    output up_ready,
    input  dn_ready,
    output dn_valid, dn_pc, dn_inst, dn_data, dn_rf_waddr, dn_exc,
    output dn_exc_code, dn_int, dn_exc_any, dn_rf_we
  );

  modport master (
    output flush, ext_int,
    output up_valid, up_pc, up_inst, up_data, up_rf_we, up_rf_waddr, up_exc, up_int,
    input  up_ready,
    output dn_ready,
    input  dn_valid, dn_pc, dn_inst, dn_data, dn_rf_waddr, dn_exc,
    input  dn_exc_code, dn_int, dn_exc_any, dn_rf_we
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Pipeline boundary register for one instruction's retirement payload with a
// valid/ready handshake on both sides. SKID=1 adds a second (skid) entry so
// up_ready is a pure function of state; SKID=0 is a single register whose
// ready passes dn_ready through combinationally.
// The head entry is also decoded: lowest-set exception bit -> cause code,
// interrupt merge with ext_int, and register-file write gating.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   bus          pipe_stage_skid_if.slave (flush, ext_int, up_*, dn_*)
//   dbg_state_o  FSM state (0 EMPTY, 1 ONE, 2 TWO)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int XLEN   = 32,
  parameter int RF_AW  = 5,
  parameter int EXC_W  = 4,
  parameter int SKID   = 1,
  parameter int CODE_W = (EXC_W > 1) ? $clog2(EXC_W) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_stage_skid_if.slave   bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  inst;
    logic [XLEN-1:0]  data;
    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [EXC_W-1:0] exc;
    logic             intr;
  } entry_t;

  state_e state_q, state_d;
  entry_t m_q, m_d;   // head entry, drives dn_*
  entry_t s_q, s_d;   // skid entry, only reachable when SKID != 0
  entry_t up_entry;
  logic   up_ready;
  logic   dn_valid;

  assign up_entry = '{pc:       bus.up_pc,
                      inst:     bus.up_inst,
                      data:     bus.up_data,
                      rf_we:    bus.up_rf_we,
                      rf_waddr: bus.up_rf_waddr,
                      exc:      bus.up_exc,
                      intr:     bus.up_int};

  assign dn_valid = (state_q != EMPTY);

  // With a skid entry, ready comes from state alone so no dn_ready->up_ready
  // path exists; without it, a full register frees up when the head leaves.
  assign up_ready = (SKID != 0) ? (state_q != TWO) : (bus.dn_ready | ~dn_valid);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (bus.flush) begin
      // Flush wins over every transition, including a concurrent upstream push.
      state_d = EMPTY;
      m_d     = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (bus.up_valid) begin
            m_d     = up_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (bus.dn_ready && bus.up_valid) begin
            m_d = up_entry;
          end else if (bus.dn_ready) begin
            // M keeps its old contents; only validity drops.
            state_d = EMPTY;
          end else if (bus.up_valid && (SKID != 0)) begin
            s_d     = up_entry;
            state_d = TWO;
          end
        end
        TWO: begin
          if (bus.dn_ready) begin
            m_d     = s_q;
            s_d     = '0;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  // Lowest set exception bit wins: scan from the top so lower bits overwrite.
  logic [CODE_W-1:0] exc_code;
  always_comb begin
    exc_code = '0;
    for (int i = EXC_W - 1; i >= 0; i--) begin
      if (m_q.exc[i]) exc_code = CODE_W'(i);
    end
  end

  logic dn_int;
  logic dn_exc_any;

  // ext_int only counts against an instruction actually sitting at the head.
  assign dn_int     = m_q.intr | (bus.ext_int & dn_valid);
  assign dn_exc_any = (|m_q.exc) | dn_int;

  assign bus.up_ready    = up_ready;
  assign bus.dn_valid    = dn_valid;
  assign bus.dn_pc       = m_q.pc;
  assign bus.dn_inst     = m_q.inst;
  assign bus.dn_data     = m_q.data;
  assign bus.dn_rf_waddr = m_q.rf_waddr;
  assign bus.dn_exc      = m_q.exc;
  assign bus.dn_exc_code = exc_code;
  assign bus.dn_int      = dn_int;
  assign bus.dn_exc_any  = dn_exc_any;
  assign bus.dn_rf_we    = m_q.rf_we & ~dn_exc_any & dn_valid;

  assign dbg_state_o = state_q;

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline boundary register that carries one instruction's retirement payload (PC, instruction, register-file write request, result data, exception vector, interrupt flag) between two core stages, typically MEM→WB. Unlike the fixed single-register stage, it supports true downstream backpressure through a valid/ready handshake. With `SKID=1` it adds a second (skid) entry, so `up_ready` has no combinational path from `dn_ready`. It also encodes the exception vector into a cause index and gates the register-file write enable on exceptions and interrupts.

## Interface
- `XLEN`, 32: PC, instruction and data width.
- `RF_AW`, 5: register-file address width.
- `EXC_W`, 4: exception vector width; bit i set means cause i.
- `SKID`, 1: 1 = two-entry skid buffer; 0 = single register with combinational ready.
- `CODE_W`, `$clog2(EXC_W)` (minimum 1): width of the cause code.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush` in 1: synchronous pipeline flush.
- `ext_int` in 1: asynchronous-source interrupt request, already synchronised.
- `up_valid` in 1: upstream has a payload.
- `up_ready` out 1: stage accepts a payload this cycle.
- `up_pc` / `up_inst` / `up_data` in XLEN each: upstream payload.
- `up_rf_we` in 1: upstream register-file write request.
- `up_rf_waddr` in RF_AW: upstream write address.
- `up_exc` in EXC_W: upstream exception vector.
- `up_int` in 1: upstream interrupt flag.
- `dn_valid` out 1: head entry valid.
- `dn_ready` in 1: downstream consumes the head entry.
- `dn_pc` / `dn_inst` / `dn_data` out XLEN each: head payload.
- `dn_rf_waddr` out RF_AW: head write address.
- `dn_exc` out EXC_W: head exception vector.
- `dn_exc_code` out CODE_W: head cause code.
- `dn_int` out 1: head interrupt flag.
- `dn_exc_any` out 1: exception or interrupt present.
- `dn_rf_we` out 1: gated register-file write enable.

## Operation
- A transfer occurs on a rising edge where valid and ready are both 1, on either port.
- Storage:
  - main entry M: always the head; drives all `dn_*` outputs.
  - skid entry S: present only when `SKID=1`.
- `SKID=1` state machine:
  - States are EMPTY, ONE and TWO.
  - `up_ready` = (state != TWO). It is derived from state only.
  - EMPTY: `up_valid` → load M, go to ONE.
  - ONE, `dn_ready` & `up_valid` → reload M, stay in ONE.
  - ONE, `dn_ready` & !`up_valid` → EMPTY.
  - ONE, !`dn_ready` & `up_valid` → load S, go to TWO.
  - ONE, otherwise → hold.
  - TWO, `dn_ready` → M <= S, go to ONE. `up_valid` is ignored because `up_ready` = 0.
  - TWO, otherwise → hold.
- `SKID=0` behaviour:
  - `up_ready` = `dn_ready` | !`dn_valid`.
  - M loads whenever `up_valid` & `up_ready`.
  - `dn_valid` clears on `dn_ready` with no new load.
- `dn_valid` = (state != EMPTY).
- Held payload is never modified while `dn_ready` = 0.
- Exception and interrupt decode:
  - `dn_int` = M.int | `ext_int`. The `ext_int` term applies only while `dn_valid` = 1; otherwise it is masked to 0.
  - `dn_exc_any` = (|M.exc) | `dn_int`.
  - `dn_exc_code` = index of the lowest set bit of M.exc; 0 when M.exc = 0.
  - `dn_rf_we` = M.rf_we & !`dn_exc_any` & `dn_valid`.
- Flush:
  - Next state = EMPTY; M and S are cleared to zero.
  - Any upstream handshake in the flush cycle is discarded.
  - Flush overrides all transitions. Reset overrides flush.

## Timing
- Reset (sampled `rst_n` = 0):
  - State = EMPTY; M and S are all-zero.
  - `dn_valid` = 0, `dn_rf_we` = 0, `dn_exc_any` = 0 (with `dn_valid` = 0), `dn_exc_code` = 0.
  - `up_ready` = 1 (both SKID modes).
- Latency: 1 cycle from an accepted upstream transfer to `dn_valid`.
- Throughput: one transfer per cycle when `dn_ready` is held at 1.
- SKID=1 stall recovery:
  - One transfer can complete in the same cycle `dn_ready` falls; it lands in S.
  - `up_ready` re-asserts the cycle after the first `dn_ready` in TWO.
- The decode outputs (`dn_exc_code`, `dn_int`, `dn_exc_any`, `dn_rf_we`) are combinational from M and `ext_int`, with no cycle of delay.
- Boundary conditions:
  - Flush in TWO drops both entries.
  - Flush with `up_valid` & `up_ready` drops the incoming payload.
  - Reset mid-stall empties immediately on that edge.

## Test plan
- Reset then stream: after reset, check `up_ready` = 1, `dn_valid` = 0. Drive 4 transfers with pc 0x100..0x10C and `dn_ready` = 1. Expect `dn_pc` 0x100..0x10C on consecutive cycles, one cycle after each accept.
- Skid fill, SKID=1: with `dn_ready` = 0, push pc 0x200 then 0x204. Expect `up_ready` = 0 after the second push and `dn_pc` holding 0x200. Raise `dn_ready`: expect 0x200, then 0x204, then `up_ready` = 1 again.
- Exception gating: push `rf_we` = 1, `exc` = 4'b0110. Expect `dn_exc_code` = 1, `dn_exc_any` = 1, `dn_rf_we` = 0. Push a clean entry, then pulse `ext_int` for 1 cycle while it is at the head: expect `dn_rf_we` = 0 only in that cycle.
- Flush in TWO with a concurrent push: expect the next cycle `dn_valid` = 0 and all `dn_*` data zero. The concurrent payload must never appear on `dn_*`.
- SKID=0 build: with `dn_ready` = 0 and `dn_valid` = 1, expect `up_ready` = 0 in the same cycle. Toggle `dn_ready` = 1 with `up_valid` = 1: expect a back-to-back reload with no bubble.
- Reset mid-stall: reset asserted in TWO. Expect state EMPTY, `dn_valid` = 0, `up_ready` = 1 on the next edge.
